// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time, sequenced by an IDLE/EXEC/RESP FSM.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_overflow,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_overflow,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             grant0_s;
    logic             grant1_s;
    logic             idle_s;
    logic             rsp_hs_s;

    // rr_q names the requester that wins when both are valid
    assign grant0_s = req0_valid & (~req1_valid | ~rr_q);
    assign grant1_s = req1_valid & (~req0_valid | rr_q);
    assign idle_s   = (state_q == IDLE) & ~reset;

    assign req0_ready = idle_s & grant0_s;
    assign req1_ready = idle_s & grant1_s;

    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp_hs_s   = owner_q ? rsp1_ready : rsp0_ready;

    assign rsp0_result   = res_q;
    assign rsp0_zero     = zero_q;
    assign rsp0_overflow = ovf_q;
    assign rsp1_result   = res_q;
    assign rsp1_zero     = zero_q;
    assign rsp1_overflow = ovf_q;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign busy        = (state_q != IDLE);

    // Next-state logic: grant and latch in IDLE, capture ALU in EXEC, hold in RESP
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    owner_d = 1'b0;
                    state_d = EXEC;
                end else if (req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    owner_d = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                ovf_d   = alu_overflow;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs_s) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, operand and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            op_q    <= 4'b0000;
            res_q   <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference ALU drives the alu_* inputs,
// expected responses are queued at request time and popped on response handshakes.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_overflow;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_overflow;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [3:0]  req0_op, req1_op, alu_control;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero, alu_overflow, busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp0_q[$];
    exp_t exp1_q[$];
    bit   order_q[$];

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'b0110: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic monitor_rsp();
        exp_t e;
        bit   ord;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp0_valid || rsp1_valid) begin
                    checks++;
                    if (rsp0_valid && rsp1_valid) begin
                        failures++;
                        $display("FAIL rsp_exclusive: rsp0_valid=%b rsp1_valid=%b, required one-hot", rsp0_valid, rsp1_valid);
                    end
                end
                if (rsp0_valid && rsp0_ready) begin
                    checks++;
                    if (exp0_q.size() == 0 || order_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp0_unexpected: got result=%h, required no response", rsp0_result);
                    end else begin
                        e   = exp0_q.pop_front();
                        ord = order_q.pop_front();
                        if (ord !== 1'b0) begin
                            failures++;
                            $display("FAIL order: got rsp from 0, required requester %0d", ord);
                        end
                        if ({rsp0_result, rsp0_zero, rsp0_overflow} !== {e.r, e.z, e.o}) begin
                            failures++;
                            $display("FAIL rsp0_data: got %h z=%b o=%b, required %h z=%b o=%b",
                                     rsp0_result, rsp0_zero, rsp0_overflow, e.r, e.z, e.o);
                        end
                    end
                end
                if (rsp1_valid && rsp1_ready) begin
                    checks++;
                    if (exp1_q.size() == 0 || order_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp1_unexpected: got result=%h, required no response", rsp1_result);
                    end else begin
                        e   = exp1_q.pop_front();
                        ord = order_q.pop_front();
                        if (ord !== 1'b1) begin
                            failures++;
                            $display("FAIL order: got rsp from 1, required requester %0d", ord);
                        end
                        if ({rsp1_result, rsp1_zero, rsp1_overflow} !== {e.r, e.z, e.o}) begin
                            failures++;
                            $display("FAIL rsp1_data: got %h z=%b o=%b, required %h z=%b o=%b",
                                     rsp1_result, rsp1_zero, rsp1_overflow, e.r, e.z, e.o);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && (exp0_q.size() != 0 || exp1_q.size() != 0); c++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            failures++;
            $display("FAIL rsp_timeout: pending rsp0=%0d rsp1=%0d, required 0", exp0_q.size(), exp1_q.size());
        end
    endtask

    task automatic run(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op0, input exp_t e0,
                       input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] op1, input exp_t e1);
        bit d0, d1, g0, g1;
        if (v0) exp0_q.push_back(e0);
        if (v1) exp1_q.push_back(e1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        d0 = !v0;
        d1 = !v1;
        for (int c = 0; c < 40 && !(d0 && d1); c++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            checks++;
            if (g0 && g1) begin
                failures++;
                $display("FAIL ready_exclusive: req0_ready=%b req1_ready=%b, required at most one", g0, g1);
            end
            @(posedge clk);
            #1;
            if (g0) begin req0_valid = 1'b0; d0 = 1'b1; end
            if (g1) begin req1_valid = 1'b0; d1 = 1'b1; end
        end
        checks++;
        if (!(d0 && d1)) begin
            failures++;
            $display("FAIL grant_timeout: done0=%b done1=%b, required 1 1", d0, d1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        drain();
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_handshake: rdy0=%b rdy1=%b rv0=%b rv1=%b busy=%b, required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
        end
        checks++;
        if ({alu_a, alu_b, alu_control} !== {32'd0, 32'd0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_alu: a=%h b=%h ctl=%b, required 0 0 0000", alu_a, alu_b, alu_control);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, busy, alu_control} !== 7'b0000000) begin
            failures++;
            $display("FAIL idle_after_reset: rdy0=%b rdy1=%b busy=%b ctl=%b, required 0 0 0 0000",
                     req0_ready, req1_ready, busy, alu_control);
        end
    endtask

    task automatic test_single_latency();
        exp0_q.push_back({32'd3, 1'b0, 1'b0});
        order_q.push_back(1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd1; req0_op = 4'b0010;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL req0_ready_same_cycle: got %b, required 1", req0_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp0_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL latency_exec: rsp0_valid=%b busy=%b, required 0 1", rsp0_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
            failures++;
            $display("FAIL latency_resp: rsp0_valid=%b rsp1_valid=%b, required 1 0", rsp0_valid, rsp1_valid);
        end
        drain();
    endtask

    task automatic test_round_robin();
        reset_dut();
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        run(1'b1, 32'd2, 32'd1, 4'b0110, {32'd1, 1'b0, 1'b0},
            1'b1, 32'd1, 32'd2, 4'b0111, {32'd1, 1'b0, 1'b0});
        order_q.push_back(1'b0);
        run(1'b1, 32'd10, 32'd20, 4'b0010, {32'd30, 1'b0, 1'b0},
            1'b0, 32'd0, 32'd0, 4'b0000, {32'd0, 1'b0, 1'b0});
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        run(1'b1, 32'd6, 32'd3, 4'b0000, {32'd2, 1'b0, 1'b0},
            1'b1, 32'd4, 32'd1, 4'b0001, {32'd5, 1'b0, 1'b0});
    endtask

    task automatic test_backpressure();
        exp1_q.push_back({32'hFFFF_FFFC, 1'b0, 1'b0});
        order_q.push_back(1'b1);
        @(posedge clk);
        #1;
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd1; req1_op = 4'b1100;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_req1_grant: got %b, required 1", req1_ready);
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        exp0_q.push_back({32'd11, 1'b0, 1'b0});
        order_q.push_back(1'b0);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_op = 4'b0010;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_exec_ready: req0_ready=%b, required 0", req0_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp1_valid, rsp0_valid, req0_ready, req1_ready} !== 4'b1000 ||
                rsp1_result !== 32'hFFFF_FFFC || alu_a !== 32'd2 || alu_control !== 4'b1100) begin
                failures++;
                $display("FAIL bp_hold[%0d]: rv1=%b rv0=%b rdy0=%b rdy1=%b res=%h a=%h ctl=%b, required 1 0 0 0 fffffffc 00000002 1100",
                         i, rsp1_valid, rsp0_valid, req0_ready, req1_ready, rsp1_result, alu_a, alu_control);
            end
        end
        @(posedge clk);
        #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_grant: req0_ready=%b, required 1", req0_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        drain();
    endtask

    task automatic test_flags();
        order_q.push_back(1'b0);
        run(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010, {32'h8000_0000, 1'b0, 1'b1},
            1'b0, 32'd0, 32'd0, 4'b0000, {32'd0, 1'b0, 1'b0});
        order_q.push_back(1'b0);
        run(1'b1, 32'd2, 32'd2, 4'b0110, {32'd0, 1'b1, 1'b0},
            1'b0, 32'd0, 32'd0, 4'b0000, {32'd0, 1'b0, 1'b0});
        order_q.push_back(1'b1);
        run(1'b0, 32'd0, 32'd0, 4'b0000, {32'd0, 1'b0, 1'b0},
            1'b1, 32'd2, 32'd1, 4'b0000, {32'd0, 1'b1, 1'b0});
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0010;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_grant: req1_ready=%b, required 1", req1_ready);
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_exec_busy: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, rsp1_valid, alu_a, alu_control} !== {1'b0, 1'b0, 32'd0, 4'b0000}) begin
            failures++;
            $display("FAIL rst_mid_clear: busy=%b rv1=%b a=%h ctl=%b, required 0 0 0 0000",
                     busy, rsp1_valid, alu_a, alu_control);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp1_valid, busy} !== 2'b00) begin
                failures++;
                $display("FAIL rst_mid_no_rsp[%0d]: rv1=%b busy=%b, required 0 0", i, rsp1_valid, busy);
            end
        end
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        run(1'b1, 32'd9, 32'd4, 4'b0110, {32'd5, 1'b0, 1'b0},
            1'b1, 32'd1, 32'd1, 4'b0010, {32'd2, 1'b0, 1'b0});
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'b0000;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'b0000;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        fork
            monitor_rsp();
        join_none
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_flags();
        test_reset_mid_op();
        checks++;
        if (order_q.size() != 0) begin
            failures++;
            $display("FAIL order_leftover: pending=%0d, required 0", order_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
